// File: rtl/regfile_pro_pkg.sv
// Shared constants, FSM encodings and helpers for the regfile_pro register file.
package regfile_pro_pkg;

  localparam int unsigned H_IDX = 4;
  localparam int unsigned L_IDX = 5;

  typedef enum logic [1:0] {
    ID_IDLE = 2'd0,
    ID_CALC = 2'd1,
    ID_WB   = 2'd2
  } id_state_e;

  typedef enum logic [1:0] {
    SN_IDLE    = 2'd0,
    SN_SAVE    = 2'd1,
    SN_RESTORE = 2'd2
  } sn_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // SP lives in the last pair of the array.
  function automatic int unsigned sp_pair(input int unsigned nregs);
    return nregs / 2 - 1;
  endfunction

endpackage

// File: rtl/regfile_pro_incdec.sv
// Registered pair increment/decrement engine: latch pair, add/sub 1, write back.
module regfile_pro_incdec
  import regfile_pro_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_req,
  input  logic [PW-1:0] id_sel,
  input  logic          id_dec,
  input  logic          snap_busy,
  input  logic [2*DW-1:0] pair_val,
  output logic [PW-1:0] pair_sel,
  output logic          wb_en,
  output logic [2*DW-1:0] wb_data,
  output logic          id_busy,
  output logic          id_done
);

  localparam logic [2*DW-1:0] One = {{(2*DW-1){1'b0}}, 1'b1};

  id_state_e       state_q, state_d;
  logic [PW-1:0]   sel_q;
  logic            dec_q;
  logic [2*DW-1:0] res_q;
  logic            accept;

  assign accept = (state_q == ID_IDLE) && id_req && !snap_busy;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ID_IDLE: if (accept) state_d = ID_CALC;
      ID_CALC: state_d = ID_WB;
      ID_WB:   state_d = ID_IDLE;
      default: state_d = ID_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ID_IDLE;
      sel_q   <= '0;
      dec_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q <= id_sel;
        dec_q <= id_dec;
      end
      // Modulo 2^(2*DW) wrap falls out of the fixed-width add/sub.
      if (state_q == ID_CALC) res_q <= dec_q ? (pair_val - One) : (pair_val + One);
    end
  end

  assign pair_sel = sel_q;
  assign wb_en    = (state_q == ID_WB);
  assign wb_data  = res_q;
  assign id_busy  = (state_q != ID_IDLE);
  assign id_done  = (state_q == ID_WB);

endmodule

// File: rtl/regfile_pro.sv
// Byte register file with pair ports, inc/dec engine and shadow snapshot engine.
// Define REGFILE_PRO_BYPASS_EN for write-through forwarding on all read outputs.
module regfile_pro
  import regfile_pro_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned NREGS = 8,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = clog2(NREGS),
  localparam int unsigned PW   = AW - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  input  logic [PW-1:0]     rdw_sel,
  output logic [2*DW-1:0]   rdw_data,
  output logic [DW-1:0]     h,
  output logic [DW-1:0]     l,
  output logic [2*DW-1:0]   sp,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              wrw_en,
  input  logic [PW-1:0]     wrw_sel,
  input  logic [2*DW-1:0]   wrw_data,
  input  logic              id_req,
  input  logic [PW-1:0]     id_sel,
  input  logic              id_dec,
  output logic              id_busy,
  output logic              id_done,
  input  logic              snap_save,
  input  logic              snap_restore,
  output logic              snap_busy
);

  localparam int unsigned SpHi = 2 * sp_pair(NREGS);
  localparam int unsigned SpLo = SpHi + 1;

  logic [DW-1:0]    regs_q   [NREGS];
  logic [DW-1:0]    shadow_q [NREGS];
  logic [DW-1:0]    nxt      [NREGS];
  logic [DW-1:0]    view     [NREGS];
  logic [NREGS-1:0] we;

  logic [PW-1:0]    id_pair_sel;
  logic             id_wb_en;
  logic [2*DW-1:0]  id_wb_data;
  logic [2*DW-1:0]  id_pair_val;

  sn_state_e        sn_state_q, sn_state_d;
  logic [AW-1:0]    sn_idx_q, sn_idx_d;

  assign id_pair_val = {regs_q[{id_pair_sel, 1'b0}], regs_q[{id_pair_sel, 1'b1}]};

  regfile_pro_incdec #(
    .DW (DW),
    .PW (PW)
  ) u_incdec (
    .clk       (clk),
    .rst       (rst),
    .id_req    (id_req),
    .id_sel    (id_sel),
    .id_dec    (id_dec),
    .snap_busy (snap_busy),
    .pair_val  (id_pair_val),
    .pair_sel  (id_pair_sel),
    .wb_en     (id_wb_en),
    .wb_data   (id_wb_data),
    .id_busy   (id_busy),
    .id_done   (id_done)
  );

  // Snapshot engine: one register per cycle, index 0..NREGS-1.
  always_comb begin
    sn_state_d = sn_state_q;
    sn_idx_d   = sn_idx_q;
    unique case (sn_state_q)
      SN_IDLE: begin
        if ((snap_save || snap_restore) && !id_busy) begin
          sn_state_d = snap_save ? SN_SAVE : SN_RESTORE;
          sn_idx_d   = '0;
        end
      end
      SN_SAVE, SN_RESTORE: begin
        sn_idx_d = sn_idx_q + 1'b1;
        if (sn_idx_q == AW'(NREGS - 1)) sn_state_d = SN_IDLE;
      end
      default: sn_state_d = SN_IDLE;
    endcase
  end

  assign snap_busy = (sn_state_q != SN_IDLE);

  // Per-byte write priority: wrw > wr > inc/dec write-back > restore copy.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      we[i]  = 1'b0;
      nxt[i] = regs_q[i];
      if (wrw_en && wrw_sel == PW'(i / 2)) begin
        we[i]  = 1'b1;
        nxt[i] = (i % 2 == 0) ? wrw_data[2*DW-1:DW] : wrw_data[DW-1:0];
      end else if (wr_en && wr_addr == AW'(i)) begin
        we[i]  = 1'b1;
        nxt[i] = wr_data;
      end else if (id_wb_en && id_pair_sel == PW'(i / 2)) begin
        we[i]  = 1'b1;
        nxt[i] = (i % 2 == 0) ? id_wb_data[2*DW-1:DW] : id_wb_data[DW-1:0];
      end else if (sn_state_q == SN_RESTORE && sn_idx_q == AW'(i)) begin
        we[i]  = 1'b1;
        nxt[i] = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      sn_state_q <= SN_IDLE;
      sn_idx_q   <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we[i]) regs_q[i] <= nxt[i];
      end
      // Save captures the pre-edge value, ignoring same-cycle writes.
      if (sn_state_q == SN_SAVE) shadow_q[sn_idx_q] <= regs_q[sn_idx_q];
      sn_state_q <= sn_state_d;
      sn_idx_q   <= sn_idx_d;
    end
  end

`ifdef REGFILE_PRO_BYPASS_EN
  always_comb begin
    for (int i = 0; i < NREGS; i++) view[i] = we[i] ? nxt[i] : regs_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NREGS; i++) view[i] = regs_q[i];
  end
`endif

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) rd_data[k*DW +: DW] = view[rd_addr[k*AW +: AW]];
  end

  assign rdw_data = {view[{rdw_sel, 1'b0}], view[{rdw_sel, 1'b1}]};
  assign h        = view[AW'(H_IDX)];
  assign l        = view[AW'(L_IDX)];
  assign sp       = {view[AW'(SpHi)], view[AW'(SpLo)]};

endmodule
